// File: rtl/clock_pkg.sv
// Shared clock types: time-of-day struct, alarm ring-state encoding and field limits.
package clock_pkg;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  typedef struct packed {
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } clock_time_t;

  typedef enum logic [1:0] {
    RING_IDLE    = 2'd0,
    RING_RINGING = 2'd1,
    RING_SNOOZE  = 2'd2
  } ring_state_e;

endpackage

// File: rtl/time_add_min.sv
// Combinational time + N_MIN minutes; minutes wrap at 60 with carry, hours wrap at 24.
module time_add_min
  import clock_pkg::*;
#(
  parameter int unsigned N_MIN = 5
) (
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [6:0] hour,
  output logic [6:0] sum_sec,
  output logic [6:0] sum_min,
  output logic [6:0] sum_hour
);

  logic [7:0] min_raw;
  logic [7:0] min_wrap;
  logic [7:0] hour_raw;
  logic [7:0] hour_wrap;
  logic       carry;

  always_comb begin
    min_raw   = {1'b0, min} + 8'(N_MIN);
    min_wrap  = min_raw - 8'd60;
    carry     = (min_raw > {1'b0, MIN_MAX});
    hour_raw  = {1'b0, hour} + {7'd0, carry};
    hour_wrap = hour_raw - 8'd24;
    sum_sec   = sec;
    sum_min   = carry ? min_wrap[6:0] : min_raw[6:0];
    sum_hour  = (hour_raw > {1'b0, HOUR_MAX}) ? hour_wrap[6:0] : hour_raw[6:0];
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: match detect, bounded snooze/re-ring loop, ring timeout.
// Optional ALARM_RING_PULSE_EN: ring toggles on each tick while RINGING (0.5 Hz beep).
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [6:0] cur_sec,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_hour,
  input  logic [6:0] alm_sec,
  input  logic [6:0] alm_min,
  input  logic [6:0] alm_hour,
  input  logic       alm_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       ring,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic [1:0] state
);

  ring_state_e st;
  clock_time_t target;
  clock_time_t cur_t;
  clock_time_t alm_t;
  clock_time_t tgt_next;
  logic [6:0]  tmo_cnt;
  logic        alm_match;
  logic        tgt_hit;
  logic        snooze_ok;
  logic        tmo_hit;

  assign cur_t = '{hour: cur_hour, min: cur_min, sec: cur_sec};
  assign alm_t = '{hour: alm_hour, min: alm_min, sec: alm_sec};

  time_add_min #(.N_MIN(SNOOZE_MIN)) u_snooze_add (
    .sec      (cur_sec),
    .min      (cur_min),
    .hour     (cur_hour),
    .sum_sec  (tgt_next.sec),
    .sum_min  (tgt_next.min),
    .sum_hour (tgt_next.hour)
  );

  assign alm_match = tick_1hz && alm_en && (cur_t == alm_t);
  assign tgt_hit   = tick_1hz && (cur_t == target);
  assign snooze_ok = snooze_btn && (snooze_cnt < 3'(MAX_SNOOZE));
  // Expires on the RING_TIMEOUT_S-th tick after entry; the entry tick itself is not counted.
  assign tmo_hit   = tick_1hz && (tmo_cnt == 7'(RING_TIMEOUT_S - 1));
  assign state     = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= RING_IDLE;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= 3'd0;
      tmo_cnt    <= 7'd0;
      target     <= '0;
    end else if (!alm_en) begin
      st         <= RING_IDLE;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= 3'd0;
      tmo_cnt    <= 7'd0;
    end else begin
      case (st)
        RING_IDLE: begin
          if (alm_match && !stop_btn) begin
            st         <= RING_RINGING;
            ring       <= 1'b1;
            snooze_cnt <= 3'd0;
            tmo_cnt    <= 7'd0;
          end
        end
        RING_RINGING: begin
          if (stop_btn || (!snooze_ok && tmo_hit)) begin
            st         <= RING_IDLE;
            ring       <= 1'b0;
            snooze_cnt <= 3'd0;
            tmo_cnt    <= 7'd0;
          end else if (snooze_ok) begin
            st         <= RING_SNOOZE;
            ring       <= 1'b0;
            snoozing   <= 1'b1;
            snooze_cnt <= snooze_cnt + 3'd1;
            target     <= tgt_next;
          end else if (tick_1hz) begin
            tmo_cnt <= tmo_cnt + 7'd1;
`ifdef ALARM_RING_PULSE_EN
            ring    <= ~ring;
`endif
          end
        end
        RING_SNOOZE: begin
          if (stop_btn) begin
            st         <= RING_IDLE;
            snoozing   <= 1'b0;
            snooze_cnt <= 3'd0;
          end else if (tgt_hit) begin
            st       <= RING_RINGING;
            ring     <= 1'b1;
            snoozing <= 1'b0;
            tmo_cnt  <= 7'd0;
          end
        end
        default: begin
          st       <= RING_IDLE;
          ring     <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl (default build, SNOOZE_MIN=5, RING_TIMEOUT_S=60, MAX_SNOOZE=3).
module tb_alarm_ring_ctrl;

  localparam int W = 7;  // {ring, snoozing, snooze_cnt[2:0], state[1:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [6:0] cur_sec, cur_min, cur_hour;
  logic [6:0] alm_sec, alm_min, alm_hour;
  logic       alm_en, stop_btn, snooze_btn;
  logic       ring, snoozing;
  logic [2:0] snooze_cnt;
  logic [1:0] state;

  int th, tm, ts;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_name_q[$];

  alarm_ring_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .cur_sec    (cur_sec),
    .cur_min    (cur_min),
    .cur_hour   (cur_hour),
    .alm_sec    (alm_sec),
    .alm_min    (alm_min),
    .alm_hour   (alm_hour),
    .alm_en     (alm_en),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .ring       (ring),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- expected-value helpers ----------------
  function automatic logic [W-1:0] e_idle();
    return {1'b0, 1'b0, 3'd0, 2'd0};
  endfunction
  function automatic logic [W-1:0] e_ring(input int n);
    return {1'b1, 1'b0, 3'(n), 2'd1};
  endfunction
  function automatic logic [W-1:0] e_snz(input int n);
    return {1'b0, 1'b1, 3'(n), 2'd2};
  endfunction

  task automatic expect_out(input logic [W-1:0] v, input string name);
    exp_q.push_back(v);
    exp_cyc_q.push_back(cyc);
    exp_name_q.push_back(name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic tk, input logic stp, input logic snz);
    tick_1hz   = tk;
    cur_hour   = 7'(th);
    cur_min    = 7'(tm);
    cur_sec    = 7'(ts);
    stop_btn   = stp;
    snooze_btn = snz;
    @(posedge clk);
    #1;
    tick_1hz   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
  endtask

  task automatic set_alarm(input int h, input int m, input int s);
    alm_hour = 7'(h); alm_min = 7'(m); alm_sec = 7'(s);
  endtask

  // One quiet cycle, then the seconds tick carrying the new time.
  task automatic tick_sec(input logic stp, input logic snz);
    drive(1'b0, 1'b0, 1'b0);
    ts = ts + 1;
    if (ts == 60) begin ts = 0; tm = tm + 1; end
    if (tm == 60) begin tm = 0; th = th + 1; end
    if (th == 24) th = 0;
    drive(1'b1, stp, snz);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick_sec(1'b0, 1'b0);
  endtask

  task automatic tick_until(input int h, input int m, input int s);
    int guard;
    guard = 0;
    while (!(th == h && tm == m && ts == s) && guard < 4000) begin
      tick_sec(1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic press(input logic stp, input logic snz);
    drive(1'b0, stp, snz);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        n;
      int           c;
      e = exp_q.pop_front();
      c = exp_cyc_q.pop_front();
      n = exp_name_q.pop_front();
      a = {ring, snoozing, snooze_cnt, state};
      checks++;
      if (c != cyc) begin
        failures++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", n, cyc, c);
      end else if (a !== e) begin
        failures++;
        $display("FAIL %s: got ring=%b snoozing=%b cnt=%0d state=%0d, required ring=%b snoozing=%b cnt=%0d state=%0d",
                 n, a[6], a[5], a[4:2], a[1:0], e[6], e[5], e[4:2], e[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; tick_1hz = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    alm_en = 1'b0;
    set_time(0, 0, 0);
    set_alarm(0, 0, 0);
    cur_hour = 7'd0; cur_min = 7'd0; cur_sec = 7'd0;
    @(posedge clk); @(posedge clk); #1;
    expect_out(e_idle(), "reset_state");
    reset = 1'b1;

    // Basic match at 07:30:00
    alm_en = 1'b1;
    set_alarm(7, 30, 0);
    set_time(7, 29, 55);
    tick_n(4);
    expect_out(e_idle(), "pre_match");
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(0), "match_ring");

    // Snooze 1 at 07:30:10 -> 07:35:10; an alarm match inside SNOOZE is ignored
    tick_n(10);
    expect_out(e_ring(0), "ringing_hold");
    press(1'b0, 1'b1);
    expect_out(e_snz(1), "snooze1");
    set_alarm(7, 32, 0);
    tick_until(7, 32, 0);
    expect_out(e_snz(1), "match_in_snooze");
    set_alarm(7, 30, 0);
    tick_until(7, 35, 9);
    expect_out(e_snz(1), "pre_rering1");
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(1), "rering1");

    // Snoozes 2 and 3, then the ignored fourth, then timeout
    tick_sec(1'b0, 1'b0);
    press(1'b0, 1'b1);
    expect_out(e_snz(2), "snooze2");
    tick_until(7, 40, 10);
    expect_out(e_snz(2), "pre_rering2");
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(2), "rering2");
    press(1'b0, 1'b1);
    expect_out(e_snz(3), "snooze3");
    tick_until(7, 45, 11);
    expect_out(e_ring(3), "rering3");
    press(1'b0, 1'b1);
    expect_out(e_ring(3), "snooze_at_max");
    tick_n(59);
    expect_out(e_ring(3), "pre_timeout");
    tick_sec(1'b0, 1'b0);
    expect_out(e_idle(), "timeout");

    // Day wrap: 23:58:00 + 5 min -> 00:03:00
    set_alarm(23, 58, 0);
    set_time(23, 57, 58);
    tick_sec(1'b0, 1'b0);
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(0), "wrap_ring");
    press(1'b0, 1'b1);
    expect_out(e_snz(1), "wrap_snooze");
    tick_until(0, 2, 59);
    expect_out(e_snz(1), "wrap_pre");
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(1), "wrap_rering");
    press(1'b1, 1'b1);
    expect_out(e_idle(), "stop_snooze_same");

    // Match and stop together in IDLE; then alm_en drop while ringing
    set_alarm(1, 0, 0);
    set_time(0, 59, 59);
    tick_sec(1'b1, 1'b0);
    expect_out(e_idle(), "match_stop_idle");
    set_alarm(1, 0, 5);
    tick_until(1, 0, 5);
    expect_out(e_ring(0), "ring_b");
    alm_en = 1'b0;
    press(1'b0, 1'b0);
    expect_out(e_idle(), "alm_en_off");
    alm_en = 1'b1;

    // Snooze on the timeout-expiry tick wins; stop in SNOOZE
    set_alarm(3, 0, 0);
    set_time(2, 59, 59);
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(0), "ring_c");
    tick_n(59);
    expect_out(e_ring(0), "pre_timeout_c");
    tick_sec(1'b0, 1'b1);
    expect_out(e_snz(1), "snooze_on_timeout");
    press(1'b1, 1'b0);
    expect_out(e_idle(), "stop_in_snooze");

    // Asynchronous reset during SNOOZE
    set_alarm(4, 0, 0);
    set_time(3, 59, 59);
    tick_sec(1'b0, 1'b0);
    expect_out(e_ring(0), "ring_d");
    press(1'b0, 1'b1);
    expect_out(e_snz(1), "snooze_d");
    @(posedge clk);
    #2;
    reset = 1'b0;
    expect_out(e_idle(), "async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    press(1'b0, 1'b0);
    expect_out(e_idle(), "post_reset");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Sequences the alarm ringing behaviour of the digital clock. It sits between the timekeeping counters, the alarm-time register bank and the buzzer driver. It detects the alarm match and drives the ring output. It also runs a snooze/re-ring loop with a bounded snooze count, and turns the alarm off automatically after a timeout. The alarm-time registers stay a pure storage block; this controller owns every decision about when the buzzer sounds.

## Interface
Parameters:
- SNOOZE_MIN, 5: minutes added to the current time when snooze is pressed; legal range 1..59.
- RING_TIMEOUT_S, 60: seconds of continuous ringing before auto-off; legal range 1..127.
- MAX_SNOOZE, 3: maximum snoozes per alarm event; legal range 0..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset reset, asynchronous, active-low; clock clk.
- tick_1hz  in  1  one-cycle pulse; cur_* already hold the new second on this cycle.
- cur_sec, cur_min, cur_hour  in  7 each  current time, binary (0..59 / 0..59 / 0..23).
- alm_sec, alm_min, alm_hour  in  7 each  programmed alarm time, binary.
- alm_en  in  1  alarm armed; level.
- stop_btn  in  1  synchronized, debounced one-cycle pulse.
- snooze_btn  in  1  synchronized, debounced one-cycle pulse.
- ring  out  1  buzzer enable.
- snoozing  out  1  high while in the SNOOZE state.
- snooze_cnt  out  3  snoozes used in the current alarm event.
- state  out  2  FSM state: 0 IDLE, 1 RINGING, 2 SNOOZE.

## Operation
- FSM states: IDLE, RINGING, SNOOZE. All outputs are registered.
- Match: tick_1hz && alm_en && cur_* == alm_*, with all three fields compared.
- IDLE → RINGING on match; snooze_cnt = 0; the timeout counter clears.
- RINGING → IDLE on stop_btn; snooze_cnt clears.
- RINGING → IDLE on timeout: RING_TIMEOUT_S ticks counted while in RINGING. Same effect as stop.
- RINGING → SNOOZE on snooze_btn when snooze_cnt < MAX_SNOOZE.
  - Snooze target = current time + SNOOZE_MIN minutes.
  - Minutes wrap at 60 and carry into hours; hours wrap at 24 (23:58 + 5 → 00:03). Seconds are unchanged.
  - snooze_cnt increments.
- RINGING with snooze_btn when snooze_cnt == MAX_SNOOZE: the press is ignored and ringing continues.
- SNOOZE → RINGING when tick_1hz && cur_* == target; the timeout counter clears.
- SNOOZE → IDLE on stop_btn; snooze_cnt clears.
- Any state → IDLE when alm_en = 0, with highest priority. snooze_cnt and the timeout counter clear.
- Priority within one cycle: alm_en low > stop_btn > snooze_btn > timeout > match.
- A snooze press on the same cycle as timeout expiry snoozes.
- An alarm match while in SNOOZE is ignored, so the snooze target governs.
- A match and stop_btn on the same cycle in IDLE: the controller stays IDLE.
- Arithmetic: target minute = cur_min + SNOOZE_MIN as an 8-bit sum, minus 60 if ≥ 60, with a carry into the hour. Out-of-range cur_* inputs are not checked.

## Timing
- Reset values: ring 0, snoozing 0, snooze_cnt 0, state IDLE, timeout counter 0, target 0.
- ring rises on the clk edge after the matching tick_1hz cycle (1-cycle latency).
- ring falls on the clk edge after the stop_btn, snooze_btn or alm_en-low cycle.
- Timeout: ring falls on the edge after the RING_TIMEOUT_S-th tick counted in RINGING. The entry tick is not counted.
- The snooze target is captured from cur_* on the snooze_btn cycle.
- Asserting reset mid-ring or mid-snooze returns every output to its reset value immediately (asynchronous).

## Configuration
- ALARM_RING_PULSE_EN defined: while in RINGING, ring toggles on every tick_1hz, starting at 1 on entry. The result is an intermittent 0.5 Hz beep.
- ALARM_RING_PULSE_EN undefined: ring is a steady 1 throughout RINGING.
- In both builds ring is 0 in IDLE and SNOOZE.

## Structure
- Shared package clock_pkg:
  - time struct (sec, min, hour, 7 bits each);
  - ring-state enum;
  - constants SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- Sub-module time_add_min: combinational time + N-minute adder with minute and hour wrap. It is reused later by other clock features.

## Test plan
- Alarm 07:30:00, alm_en = 1, time reaches 07:30:00 → ring = 1 one cycle after the tick; state = 1.
- Ringing, snooze_btn at 07:30:10 → ring = 0, snoozing = 1, snooze_cnt = 1; ring returns at 07:35:10.
- Alarm 23:58:00 with a snooze at 23:58:00 (SNOOZE_MIN = 5) → re-ring at 00:03:00.
- Three snoozes, then a fourth snooze_btn → ring stays 1 and snooze_cnt stays 3.
- No button pressed for 60 ticks in RINGING → ring = 0, state IDLE, snooze_cnt = 0.
- stop_btn and snooze_btn on the same cycle → IDLE. Separately, reset pulsed during SNOOZE → all outputs 0.
